// File: rtl/sha1_msg_padder.sv
// SHA-1 front end: packs a 32-bit word stream into padded 512-bit blocks, bursts each
// block to the sha1 core as 16 back-to-back words and captures the final digest.
module sha1_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_vld,
  output logic         msg_rdy,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic         blk_vld,
  output logic [31:0]  blk_data,
  output logic         blk_prec,
  input  logic         core_busy,
  input  logic         core_dout_vld,
  input  logic [159:0] core_dout,
  output logic         dig_vld,
  output logic [159:0] dig
);

  typedef enum logic [1:0] {S_FILL, S_PAD, S_SEND, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic [4:0]       rd_cnt_q, rd_cnt_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             first_q, first_d;
  logic             pend80_q, pend80_d;
  logic             needlen_q, needlen_d;
  logic             final_q, final_d;
  logic             len_ok_q, len_ok_d;
  logic             blk_vld_q, blk_vld_d;
  logic [31:0]      blk_data_q, blk_data_d;
  logic             blk_prec_q, blk_prec_d;
  logic             dig_vld_q, dig_vld_d;
  logic [159:0]     dig_q, dig_d;

  logic [31:0]      blk_buf_q [16];
  logic             buf_we;
  logic [3:0]       buf_waddr;
  logic [31:0]      buf_wdat;
  logic [31:0]      last_word;
  logic [63:0]      bit_len;
  logic             acc;

  assign msg_rdy  = (state_q == S_FILL) && !rst;
  assign acc      = msg_vld && msg_rdy;
  assign bit_len  = 64'({byte_cnt_q, 3'b000});
  assign blk_vld  = blk_vld_q;
  assign blk_data = blk_data_q;
  assign blk_prec = blk_prec_q;
  assign dig_vld  = dig_vld_q;
  assign dig      = dig_q;

  // Keep the valid bytes of the final word, terminate with 0x80, zero the rest.
  always_comb begin
    last_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < msg_bytes)       last_word[31-8*i -: 8] = msg_data[31-8*i -: 8];
      else if (3'(i) == msg_bytes) last_word[31-8*i -: 8] = 8'h80;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    byte_cnt_d = byte_cnt_q;
    first_d    = first_q;
    pend80_d   = pend80_q;
    needlen_d  = needlen_q;
    final_d    = final_q;
    len_ok_d   = len_ok_q;
    blk_vld_d  = 1'b0;
    blk_data_d = '0;
    blk_prec_d = 1'b0;
    dig_vld_d  = 1'b0;
    dig_d      = dig_q;
    buf_we     = 1'b0;
    buf_waddr  = wr_ptr_q;
    buf_wdat   = '0;
    unique case (state_q)
      S_FILL: begin
        if (acc) begin
          buf_we     = 1'b1;
          buf_wdat   = msg_last ? last_word : msg_data;
          byte_cnt_d = byte_cnt_q + (msg_last ? LEN_W'(msg_bytes) : LEN_W'(4));
          if (!msg_last) begin
            if (wr_ptr_q == 4'd15) begin
              wr_ptr_d = 4'd0;
              final_d  = 1'b0;
              state_d  = S_SEND;
            end else begin
              wr_ptr_d = wr_ptr_q + 4'd1;
            end
          end else begin
            if (msg_bytes == 3'd4) pend80_d = 1'b1;
            else if (wr_ptr_q <= 4'd13) len_ok_d = 1'b1;
            final_d = 1'b0;
            if (wr_ptr_q == 4'd15) begin
              wr_ptr_d  = 4'd0;
              needlen_d = 1'b1;
              state_d   = S_SEND;
            end else begin
              wr_ptr_d = wr_ptr_q + 4'd1;
              state_d  = S_PAD;
            end
          end
        end
      end
      S_PAD: begin
        buf_we = 1'b1;
        if (pend80_q) begin
          buf_wdat = 32'h8000_0000;
          pend80_d = 1'b0;
          if (wr_ptr_q <= 4'd13) len_ok_d = 1'b1;
        end else if (len_ok_q && wr_ptr_q == 4'd14) begin
          buf_wdat = bit_len[63:32];
        end else if (len_ok_q && wr_ptr_q == 4'd15) begin
          buf_wdat = bit_len[31:0];
        end
        if (wr_ptr_q == 4'd15) begin
          wr_ptr_d = 4'd0;
          state_d  = S_SEND;
          if (len_ok_q && !pend80_q) final_d = 1'b1;
          else                       needlen_d = 1'b1;
        end else begin
          wr_ptr_d = wr_ptr_q + 4'd1;
        end
      end
      S_SEND: begin
        // The core is only checked before word 0; once started the burst is unbroken.
        if (rd_cnt_q == 5'd0) begin
          if (!core_busy) begin
            blk_vld_d  = 1'b1;
            blk_data_d = blk_buf_q[0];
            blk_prec_d = !first_q;
            rd_cnt_d   = 5'd1;
          end
        end else if (rd_cnt_q == 5'd16) begin
          rd_cnt_d = 5'd0;
          first_d  = 1'b0;
          state_d  = S_WAIT;
        end else begin
          blk_vld_d  = 1'b1;
          blk_data_d = blk_buf_q[rd_cnt_q[3:0]];
          blk_prec_d = !first_q;
          rd_cnt_d   = rd_cnt_q + 5'd1;
        end
      end
      S_WAIT: begin
        if (core_dout_vld) begin
          wr_ptr_d = 4'd0;
          if (final_q) begin
            dig_d      = core_dout;
            dig_vld_d  = 1'b1;
            first_d    = 1'b1;
            byte_cnt_d = '0;
            final_d    = 1'b0;
            pend80_d   = 1'b0;
            needlen_d  = 1'b0;
            len_ok_d   = 1'b0;
            state_d    = S_FILL;
          end else if (pend80_q || needlen_q) begin
            // The 0x80 is either already sent or goes to word 0, so length fits here.
            needlen_d = 1'b0;
            len_ok_d  = 1'b1;
            state_d   = S_PAD;
          end else begin
            len_ok_d = 1'b0;
            state_d  = S_FILL;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FILL;
      wr_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      byte_cnt_q <= '0;
      first_q    <= 1'b1;
      pend80_q   <= 1'b0;
      needlen_q  <= 1'b0;
      final_q    <= 1'b0;
      len_ok_q   <= 1'b0;
      blk_vld_q  <= 1'b0;
      blk_data_q <= '0;
      blk_prec_q <= 1'b0;
      dig_vld_q  <= 1'b0;
      dig_q      <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      first_q    <= first_d;
      pend80_q   <= pend80_d;
      needlen_q  <= needlen_d;
      final_q    <= final_d;
      len_ok_q   <= len_ok_d;
      blk_vld_q  <= blk_vld_d;
      blk_data_q <= blk_data_d;
      blk_prec_q <= blk_prec_d;
      dig_vld_q  <= dig_vld_d;
      dig_q      <= dig_d;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) blk_buf_q[buf_waddr] <= buf_wdat;
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Directed bench for sha1_msg_padder with a behavioural SHA-1 core model behind it.
module tb_sha1_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         msg_vld;
  logic         msg_rdy;
  logic [31:0]  msg_data;
  logic         msg_last;
  logic [2:0]   msg_bytes;
  logic         blk_vld;
  logic [31:0]  blk_data;
  logic         blk_prec;
  logic         core_busy;
  logic         core_dout_vld;
  logic [159:0] core_dout;
  logic         dig_vld;
  logic [159:0] dig;

  logic         core_busy_m;
  logic         busy_force;
  assign core_busy = core_busy_m | busy_force;

  sha1_msg_padder #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .msg_vld(msg_vld), .msg_rdy(msg_rdy), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .blk_vld(blk_vld), .blk_data(blk_data),
    .blk_prec(blk_prec), .core_busy(core_busy), .core_dout_vld(core_dout_vld),
    .core_dout(core_dout), .dig_vld(dig_vld), .dig(dig)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] D_56    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [159:0] sha1_blk(input logic [159:0] h, input logic [511:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t, x;
    for (int i = 0; i < 16; i++) w[i] = m[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      x = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {x[30:0], x[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  // Core model: captures each 16-word burst, records it, answers after a fixed latency.
  logic [511:0] blk_mem [8];
  logic         prec_mem [8];
  int           burst_len [8];
  int           burst_start [8];
  int           nblk = 0, nburst = 0, dout_cyc = 0;
  int           cur_len = 0, wcnt = 0, lat = 0;
  logic         prev_vld = 1'b0, cur_prec = 1'b0;
  logic [511:0] words;
  logic [159:0] cv;

  initial begin
    core_busy_m = 1'b0; core_dout_vld = 1'b0; core_dout = '0; cv = IV; words = '0;
    forever begin
      @(negedge clk);
      core_dout_vld = 1'b0;
      if (blk_vld) begin
        if (!prev_vld) begin
          cur_len = 0; wcnt = 0; cur_prec = blk_prec;
          if (nburst < 8) burst_start[nburst] = cyc;
        end
        cur_len++;
        if (wcnt < 16) begin words[511-32*wcnt -: 32] = blk_data; wcnt++; end
        if (wcnt == 16 && cur_len == 16) begin
          cv = sha1_blk(cur_prec ? cv : IV, words);
          if (nblk < 8) begin blk_mem[nblk] = words; prec_mem[nblk] = cur_prec; end
          nblk++; lat = 12; core_busy_m = 1'b1;
        end
      end else if (prev_vld) begin
        if (nburst < 8) burst_len[nburst] = cur_len;
        nburst++;
      end else if (lat != 0) begin
        lat--;
        if (lat == 0) begin
          core_dout_vld = 1'b1; core_dout = cv; dout_cyc = cyc; core_busy_m = 1'b0;
        end
      end
      prev_vld = blk_vld;
      if (rst) begin lat = 0; core_busy_m = 1'b0; end
    end
  end

  logic [7:0] msg [64];

  function automatic logic [31:0] bw(input int b, input int i);
    return blk_mem[b][511-32*i -: 32];
  endfunction

  task automatic load_str(input string s);
    for (int i = 0; i < 64; i++) msg[i] = 8'hee;
    for (int i = 0; i < s.len(); i++) msg[i] = s[i];
  endtask

  task automatic clr_rec();
    nblk = 0; nburst = 0;
  endtask

  task automatic send_msg(input int n, input bit rnd);
    int nw, k, tmo;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    k = 0; tmo = 0;
    while (k < nw && tmo < 2000) begin
      @(negedge clk);
      msg_data  = {msg[4*k], msg[4*k+1], msg[4*k+2], msg[4*k+3]};
      msg_last  = (k == nw - 1);
      msg_bytes = (k == nw - 1) ? 3'(n - 4*(nw-1)) : 3'd4;
      msg_vld   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (msg_vld && msg_rdy) k++;
      tmo++;
    end
    @(negedge clk);
    msg_vld = 1'b0; msg_last = 1'b0;
    chk("send_words_accepted", 160'(k), 160'(nw));
  endtask

  task automatic wait_dig(input string tag, input bit chkdig, input logic [159:0] exp);
    int t;
    t = 0;
    while (!dig_vld && t < 3000) begin @(negedge clk); t++; end
    chk({tag, "_dig_vld"}, 160'(dig_vld), 160'(1));
    chk({tag, "_latency"}, 160'(cyc - dout_cyc), 160'(1));
    if (chkdig) chk({tag, "_digest"}, dig, exp);
    @(negedge clk);
    chk({tag, "_pulse"}, 160'(dig_vld), 160'(0));
  endtask

  int t0, rel;

  initial begin
    rst = 1'b1; msg_vld = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
    busy_force = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_msg_rdy", 160'(msg_rdy), 160'(0));
    chk("rst_blk_vld", 160'(blk_vld), 160'(0));
    chk("rst_blk_data", 160'(blk_data), 160'(0));
    chk("rst_blk_prec", 160'(blk_prec), 160'(0));
    chk("rst_dig_vld", 160'(dig_vld), 160'(0));
    chk("rst_dig", dig, 160'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_msg_rdy", 160'(msg_rdy), 160'(1));

    // "abc": the byte after 'c' carries junk that must be overwritten by 0x80.
    clr_rec(); load_str("abc");
    send_msg(3, 0);
    wait_dig("abc", 1, D_ABC);
    chk("abc_nblk", 160'(nblk), 160'(1));
    chk("abc_burst_len", 160'(burst_len[0]), 160'(16));
    chk("abc_prec", 160'(prec_mem[0]), 160'(0));
    chk("abc_w0", 160'(bw(0, 0)), 160'(32'h61626380));
    chk("abc_w14", 160'(bw(0, 14)), 160'(0));
    chk("abc_w15", 160'(bw(0, 15)), 160'(32'h00000018));

    clr_rec(); load_str("");
    send_msg(0, 0);
    wait_dig("empty", 1, D_EMPTY);
    chk("empty_nblk", 160'(nblk), 160'(1));
    chk("empty_w0", 160'(bw(0, 0)), 160'(32'h80000000));
    chk("empty_rest", 160'(blk_mem[0][479:0]), 160'(0));

    clr_rec(); load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(56, 0);
    wait_dig("m56", 1, D_56);
    chk("m56_nblk", 160'(nblk), 160'(2));
    chk("m56_prec0", 160'(prec_mem[0]), 160'(0));
    chk("m56_prec1", 160'(prec_mem[1]), 160'(1));
    chk("m56_b0w14", 160'(bw(0, 14)), 160'(32'h80000000));
    chk("m56_b0w15", 160'(bw(0, 15)), 160'(0));
    chk("m56_b1w0", 160'(bw(1, 0)), 160'(0));
    chk("m56_b1w15", 160'(bw(1, 15)), 160'(32'h000001c0));

    clr_rec();
    for (int i = 0; i < 64; i++) msg[i] = 8'(i);
    send_msg(64, 0);
    wait_dig("m64", 0, '0);
    chk("m64_nblk", 160'(nblk), 160'(2));
    chk("m64_nburst", 160'(nburst), 160'(2));
    chk("m64_len0", 160'(burst_len[0]), 160'(16));
    chk("m64_len1", 160'(burst_len[1]), 160'(16));
    chk("m64_b0w0", 160'(bw(0, 0)), 160'(32'h00010203));
    chk("m64_b0w15", 160'(bw(0, 15)), 160'(32'h3c3d3e3f));
    chk("m64_b1w0", 160'(bw(1, 0)), 160'(32'h80000000));
    chk("m64_b1w14", 160'(bw(1, 14)), 160'(0));
    chk("m64_b1w15", 160'(bw(1, 15)), 160'(32'h00000200));

    // Ragged source valid plus a busy core in front of the first block.
    clr_rec(); load_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    busy_force = 1'b1;
    send_msg(56, 1);
    repeat (10) @(negedge clk);
    chk("busy_hold_vld", 160'(blk_vld), 160'(0));
    chk("busy_hold_nburst", 160'(nburst), 160'(0));
    rel = cyc;
    busy_force = 1'b0;
    wait_dig("busy", 1, D_56);
    chk("busy_start_after_release", 160'(burst_start[0] > rel), 160'(1));
    chk("busy_nblk", 160'(nblk), 160'(2));
    chk("busy_b0w0", 160'(bw(0, 0)), 160'(32'h61626364));

    // Reset on the 7th word of a burst, then a clean "abc".
    clr_rec(); load_str("abc");
    send_msg(3, 0);
    t0 = 0;
    while (!blk_vld && t0 < 500) begin @(negedge clk); t0++; end
    chk("rstsend_burst_seen", 160'(blk_vld), 160'(1));
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstsend_blk_vld", 160'(blk_vld), 160'(0));
    chk("rstsend_msg_rdy", 160'(msg_rdy), 160'(0));
    chk("rstsend_dig", dig, 160'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rstsend_rdy_after", 160'(msg_rdy), 160'(1));
    clr_rec();
    send_msg(3, 0);
    wait_dig("abc2", 1, D_ABC);
    chk("abc2_nblk", 160'(nblk), 160'(1));
    chk("abc2_prec", 160'(prec_mem[0]), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
